spad_line_ring: RTL and testbench

//  K-line convolution scratchpad: each line takes DATA_BUS_WIDTH beats and emits FEATURE_WIDTH words.
//  All K lines pop together to form one K-tall window column.

---
 rtl/spad_line_ring_pkg.sv | 27 ++
 rtl/spad_line_ring_if.sv | 23 ++
 rtl/spad_line_fifo.sv | 55 +++++
 rtl/spad_line_ring.sv | 131 +++++++++++++
 tb/tb_spad_line_ring.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spad_line_ring_pkg.sv
// Shared sizing, types and the lane-insert helper for the K-line convolution scratchpad.
package spad_line_ring_pkg;
   localparam int KERNEL_SIZE    = 5;
   localparam int FEATURE_WIDTH  = 16;
   localparam int DATA_BUS_WIDTH = 128;
   localparam int WPB            = DATA_BUS_WIDTH / FEATURE_WIDTH;
   localparam int LINE_IDX_W     = $clog2(KERNEL_SIZE);
   localparam int DEPTH_BEATS    = 16;
   localparam int LEN_W          = 10;
   localparam int LANE_W         = $clog2(WPB);
   localparam int PTR_W          = $clog2(DEPTH_BEATS);
   localparam int CNT_W          = PTR_W + 1;

   typedef logic [FEATURE_WIDTH-1:0]  feat_t;
   typedef logic [DATA_BUS_WIDTH-1:0] beat_t;
   typedef logic [LINE_IDX_W-1:0]     line_idx_t;
   typedef logic [LEN_W-1:0]          len_t;
   typedef logic [LANE_W-1:0]         lane_t;
   typedef logic [FEATURE_WIDTH*KERNEL_SIZE-1:0] column_t;

   function automatic beat_t place_word(input beat_t b, input lane_t lane, input feat_t w);
      beat_t r;
      r = b;
      r[int'(lane)*FEATURE_WIDTH +: FEATURE_WIDTH] = w;
      return r;
   endfunction
endpackage

// File: rtl/spad_line_ring_if.sv
// Fetch-side write handshake and window-column read handshake of the scratchpad.
interface spad_line_ring_if;
   import spad_line_ring_pkg::*;

   logic      wr_valid;
   logic      wr_ready;
   line_idx_t wr_line;
   beat_t     wr_data;
   logic      rd_valid;
   logic      rd_ready;
   column_t   rd_data;
   logic      row_done;

   modport master (
      output wr_valid, wr_line, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data, row_done
   );

   modport slave (
      input  wr_valid, wr_line, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data, row_done
   );
endinterface

// File: rtl/spad_line_fifo.sv
// One scratchpad line: beat-wide write, feature-wide read in lane order 0..WPB-1.
module spad_line_fifo
   import spad_line_ring_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  logic  wr_en,
   input  beat_t wr_data,
   input  logic  pop,
   output feat_t rd_word,
   output logic  empty,
   output logic  full
);
   beat_t            mem [DEPTH_BEATS];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   lane_t            lane;
   logic [CNT_W-1:0] count;
   logic             beat_done;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH_BEATS));
   assign beat_done = pop && (lane == lane_t'(WPB - 1));
   assign rd_word   = mem[rd_ptr][int'(lane)*FEATURE_WIDTH +: FEATURE_WIDTH];

   // NOTE: the array has no reset; count and pointers alone say which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem[wr_ptr] <= wr_data;
   end

   // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lane   <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lane   <= '0;
         count  <= '0;
      end else begin
         if (wr_en)     wr_ptr <= wr_ptr + 1'b1;
         if (pop)       lane   <= beat_done ? '0 : lane + 1'b1;
         if (beat_done) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, beat_done})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/spad_line_ring.sv
// K-line scratchpad: lockstep column pops, row-reuse recirculation into line i-1, registered output.
module spad_line_ring
   import spad_line_ring_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   cfg_recirc_en,
   input  len_t                   cfg_line_len,
   spad_line_ring_if.slave        bus,
   output logic [KERNEL_SIZE-1:0] line_empty,
   output logic [KERNEL_SIZE-1:0] line_full
);
   localparam int NPK = KERNEL_SIZE - 1;

   feat_t                   dout      [KERNEL_SIZE];
   beat_t                   wr_beat   [KERNEL_SIZE];
   logic [KERNEL_SIZE-1:0]  wr_en;
   beat_t                   pk_data   [NPK];
   lane_t                   pk_lane   [NPK];
   beat_t                   pend_data [NPK];
   logic [NPK-1:0]          pend;
   logic [NPK-1:0]          pend_wr;
   logic [KERNEL_SIZE-1:0]  pend_pad;
   logic [2**LINE_IDX_W-1:0] blocked;
   logic                    pop;
   logic                    stall;
   logic                    last_col;
   logic                    rd_last;
   logic                    fetch_hs;
   len_t                    col_cnt;

   assign last_col = (col_cnt == cfg_line_len - len_t'(1));
   assign pend_pad = {1'b0, pend};
   assign pend_wr  = pend & ~line_full[NPK-1:0];
   assign stall    = |(pend & line_full[NPK-1:0]);
   assign pop      = (&(~line_empty)) && (!bus.rd_valid || bus.rd_ready) && !stall;
   assign fetch_hs = bus.wr_valid && bus.wr_ready;

   // A pending recirculated beat owns its line's write port until it lands.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      blocked = '1;
      for (int j = 0; j < KERNEL_SIZE; j++) blocked[j] = line_full[j] | pend_pad[j];
   end

   assign bus.wr_ready = ~blocked[bus.wr_line];

   always_comb begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
         wr_en[j]   = fetch_hs && (bus.wr_line == line_idx_t'(j));
         wr_beat[j] = bus.wr_data;
      end
      for (int j = 0; j < NPK; j++) begin
         if (pend_wr[j]) begin
            wr_en[j]   = 1'b1;
            wr_beat[j] = pend_data[j];
         end
      end
   end

   for (genvar g = 0; g < KERNEL_SIZE; g++) begin : g_line
      spad_line_fifo u_fifo (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .wr_en   (wr_en[g]),
         .wr_data (wr_beat[g]),
         .pop     (pop),
         .rd_word (dout[g]),
         .empty   (line_empty[g]),
         .full    (line_full[g])
      );
   end

   // Packer j collects words popped from line j+1; a row end emits early with zeroed upper lanes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         for (int j = 0; j < NPK; j++) begin
            pk_data[j] <= '0;
            pk_lane[j] <= '0;
         end
      end else if (flush) begin
         pend <= '0;
         for (int j = 0; j < NPK; j++) begin
            pk_data[j] <= '0;
            pk_lane[j] <= '0;
         end
      end else begin
         for (int j = 0; j < NPK; j++) begin
            if (pend_wr[j]) pend[j] <= 1'b0;
            if (pop && cfg_recirc_en) begin
               if (last_col || pk_lane[j] == lane_t'(WPB - 1)) begin
                  pend[j]      <= 1'b1;
                  pend_data[j] <= place_word(pk_data[j], pk_lane[j], dout[j+1]);
                  pk_data[j]   <= '0;
                  pk_lane[j]   <= '0;
               end else begin
                  pk_data[j]   <= place_word(pk_data[j], pk_lane[j], dout[j+1]);
                  pk_lane[j]   <= pk_lane[j] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         rd_last      <= 1'b0;
         col_cnt      <= '0;
      end else if (flush) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         rd_last      <= 1'b0;
         col_cnt      <= '0;
      end else if (pop) begin
         bus.rd_valid <= 1'b1;
         rd_last      <= last_col;
         col_cnt      <= last_col ? '0 : col_cnt + 1'b1;
         for (int j = 0; j < KERNEL_SIZE; j++)
            bus.rd_data[j*FEATURE_WIDTH +: FEATURE_WIDTH] <= dout[j];
      end else if (bus.rd_ready) begin
         bus.rd_valid <= 1'b0;
      end
   end

   assign bus.row_done = bus.rd_valid && bus.rd_ready && rd_last && !flush;
endmodule

// File: tb/tb_spad_line_ring.sv
// Directed bench for spad_line_ring: fill/pop, backpressure, recirculation, padding, priority, flush, reset.
module tb_spad_line_ring;
   import spad_line_ring_pkg::*;

   localparam int K  = KERNEL_SIZE;
   localparam int FW = FEATURE_WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             cfg_recirc_en = 1'b0;
   len_t             cfg_line_len = len_t'(8);
   logic [K-1:0]     line_empty;
   logic [K-1:0]     line_full;

   spad_line_ring_if bus ();

   spad_line_ring dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .cfg_recirc_en (cfg_recirc_en),
      .cfg_line_len  (cfg_line_len),
      .bus           (bus),
      .line_empty    (line_empty),
      .line_full     (line_full)
   );

   always #5 clk = ~clk;

   int      total  = 0;
   int      passed = 0;
   column_t col_q [$];
   logic    done_q [$];

   // Record every column handshake; the handshake completes on the following rising edge.
   always @(negedge clk) begin
      if (bus.rd_valid && bus.rd_ready && !flush && !rst) begin
         col_q.push_back(bus.rd_data);
         done_q.push_back(bus.row_done);
      end
   end

   function automatic beat_t beat_of(input int base);
      beat_t b;
      for (int l = 0; l < WPB; l++) b[l*FW +: FW] = feat_t'(base + l);
      return b;
   endfunction

   function automatic column_t col5(input int v [K]);
      column_t c;
      for (int i = 0; i < K; i++) c[i*FW +: FW] = feat_t'(v[i]);
      return c;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic push(input int line, input beat_t d);
      bit ok;
      ok = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_line  = line_idx_t'(line);
      bus.wr_data  = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.wr_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.wr_valid = 1'b0;
      if (!ok) begin
         total++;
         $display("FAIL push_timeout line=%0d got wr_ready=0 want 1", line);
      end
   endtask

   task automatic wait_cols(input int n);
      int i;
      i = 0;
      while (col_q.size() < n && i < 2000) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (col_q.size() < n) begin
         total++;
         $display("FAIL col_timeout got %0d columns want %0d", col_q.size(), n);
      end
   endtask

   task automatic do_flush();
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      col_q.delete();
      done_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (line_empty !== 5'h1f) $display("FAIL reset_empty got %h want 1f", line_empty); else passed++;
      total++; if (line_full !== 5'h00) $display("FAIL reset_full got %h want 00", line_full); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); else passed++;
      total++; if (bus.row_done !== 1'b0) $display("FAIL reset_row_done got %b want 0", bus.row_done); else passed++;
      total++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); else passed++;
   endtask

   task automatic test_smoke();
      int v [K];
      column_t e;
      cfg_recirc_en = 1'b0;
      cfg_line_len  = len_t'(8);
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < K; i++) push(i, beat_of(i*16));
      total++; if (line_empty !== 5'h00) $display("FAIL smoke_nonempty got %h want 00", line_empty); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL smoke_latency got rd_valid=%b want 0", bus.rd_valid); else passed++;
      @(posedge clk);
      #1;
      for (int i = 0; i < K; i++) v[i] = i*16;
      e = col5(v);
      total++; if (bus.rd_valid !== 1'b1) $display("FAIL smoke_first_valid got %b want 1", bus.rd_valid); else passed++;
      total++; if (bus.rd_data !== e) $display("FAIL smoke_first_data got %h want %h", bus.rd_data, e); else passed++;
      wait_cols(8);
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < K; i++) v[i] = i*16 + n;
         e = col5(v);
         total++; if (col_q[n] !== e) $display("FAIL smoke_col%0d got %h want %h", n, col_q[n], e); else passed++;
         total++; if (done_q[n] !== (n == 7)) $display("FAIL smoke_done%0d got %b want %b", n, done_q[n], n == 7); else passed++;
      end
      total++; if (line_empty !== 5'h1f) $display("FAIL smoke_drained got %h want 1f", line_empty); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL smoke_idle got rd_valid=%b want 0", bus.rd_valid); else passed++;
      col_q.delete();
      done_q.delete();
   endtask

   task automatic test_backpressure();
      int v [K];
      column_t e;
      bit stable;
      cfg_recirc_en = 1'b0;
      bus.rd_ready  = 1'b0;
      for (int i = 0; i < K; i++) push(i, beat_of('h100 + i*16));
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.rd_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", bus.rd_valid); else passed++;
      bus.rd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.rd_ready = 1'b0;
      for (int i = 0; i < K; i++) v[i] = 'h100 + i*16 + 3;
      e = col5(v);
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (bus.rd_data !== e || bus.rd_valid !== 1'b1) stable = 1'b0;
      end
      total++; if (stable !== 1'b1) $display("FAIL bp_stable got rd_data=%h want %h held", bus.rd_data, e); else passed++;
      total++; if (col_q.size() !== 3) $display("FAIL bp_no_pop got %0d columns want 3", col_q.size()); else passed++;
      total++; if (line_empty !== 5'h00) $display("FAIL bp_nonempty got %h want 00", line_empty); else passed++;
      bus.rd_ready = 1'b1;
      wait_cols(8);
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < K; i++) v[i] = 'h100 + i*16 + n;
         e = col5(v);
         total++; if (col_q[n] !== e) $display("FAIL bp_col%0d got %h want %h", n, col_q[n], e); else passed++;
      end
      total++; if (done_q[7] !== 1'b1) $display("FAIL bp_row_done got %b want 1", done_q[7]); else passed++;
      col_q.delete();
      done_q.delete();
   endtask

   task automatic test_recirc();
      int v [K];
      column_t e;
      do_flush();
      cfg_recirc_en = 1'b1;
      cfg_line_len  = len_t'(8);
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < K; i++) push(i, beat_of(i*16));
      push(4, beat_of('h50));
      wait_cols(16);
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < K; i++)
            v[i] = (c < 8) ? i*16 + c : ((i < 4) ? (i+1)*16 + c - 8 : 'h50 + c - 8);
         e = col5(v);
         total++; if (col_q[c] !== e) $display("FAIL recirc_col%0d got %h want %h", c, col_q[c], e); else passed++;
         total++; if (done_q[c] !== (c == 7 || c == 15)) $display("FAIL recirc_done%0d got %b want %b", c, done_q[c], c == 7 || c == 15); else passed++;
      end
      do_flush();
   endtask

   task automatic test_partial_pad();
      int v [K];
      int r;
      int n;
      column_t e;
      cfg_recirc_en = 1'b1;
      cfg_line_len  = len_t'(5);
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < K; i++) push(i, beat_of(i*16));
      push(4, beat_of('h50));
      wait_cols(15);
      for (int c = 0; c < 15; c++) begin
         r = c / 5;
         n = c % 5;
         for (int i = 0; i < K; i++) begin
            case (r)
               0:       v[i] = i*16 + n;
               1:       v[i] = (n < 3) ? i*16 + 5 + n : ((i < 4) ? (i+1)*16 + n - 3 : 'h50 + n - 3);
               default: v[i] = (i < 4) ? ((n < 3) ? (i+1)*16 + 2 + n : 0) : 'h52 + n;
            endcase
         end
         e = col5(v);
         total++; if (col_q[c] !== e) $display("FAIL pad_col%0d got %h want %h", c, col_q[c], e); else passed++;
         total++; if (done_q[c] !== (n == 4)) $display("FAIL pad_done%0d got %b want %b", c, done_q[c], n == 4); else passed++;
      end
      do_flush();
   endtask

   task automatic test_priority();
      int v [K];
      int base [K];
      column_t e;
      bit found;
      cfg_recirc_en = 1'b1;
      cfg_line_len  = len_t'(8);
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < K; i++) push(i, beat_of(i*16));
      push(4, beat_of('h50));
      push(4, beat_of('h60));
      bus.wr_line = line_idx_t'(2);
      bus.wr_data = beat_of('ha0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (!bus.wr_ready) found = 1'b1;
      end
      if (!found) begin
         total++;
         $display("FAIL prio_timeout got wr_ready=1 want 0 while recirc beat pending");
      end
      bus.wr_valid = 1'b1;
      total++; if (bus.wr_ready !== 1'b0) $display("FAIL prio_blocked got %b want 0", bus.wr_ready); else passed++;
      @(posedge clk);
      #1;
      total++; if (bus.wr_ready !== 1'b1) $display("FAIL prio_ready_next got %b want 1", bus.wr_ready); else passed++;
      @(posedge clk);
      #1 bus.wr_valid = 1'b0;
      wait_cols(24);
      for (int c = 0; c < 24; c++) begin
         for (int i = 0; i < K; i++) begin
            if (c < 8)       base[i] = i*16;
            else if (c < 16) base[i] = (i < 4) ? (i+1)*16 : 'h50;
            else             base[i] = (i == 0) ? 32 : (i == 1) ? 48 : (i == 2) ? 'ha0 : (i == 3) ? 'h50 : 'h60;
            v[i] = base[i] + c % 8;
         end
         e = col5(v);
         total++; if (col_q[c] !== e) $display("FAIL prio_col%0d got %h want %h", c, col_q[c], e); else passed++;
      end
      total++; if (done_q[23] !== 1'b1) $display("FAIL prio_row_done got %b want 1", done_q[23]); else passed++;
      do_flush();
   endtask

   task automatic test_flush();
      int v [K];
      column_t e;
      cfg_recirc_en = 1'b1;
      cfg_line_len  = len_t'(8);
      bus.rd_ready  = 1'b1;
      push(0, beat_of('h70));
      push(0, beat_of('h70));
      for (int i = 1; i < K; i++) push(i, beat_of(i*16));
      repeat (3) @(posedge clk);
      #1;
      total++; if (line_empty[0] !== 1'b0) $display("FAIL flush_pre_line0 got %b want 0", line_empty[0]); else passed++;
      do_flush();
      total++; if (line_empty !== 5'h1f) $display("FAIL flush_empty got %h want 1f", line_empty); else passed++;
      total++; if (line_full !== 5'h00) $display("FAIL flush_full got %h want 00", line_full); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL flush_rd_valid got %b want 0", bus.rd_valid); else passed++;
      total++; if (bus.wr_ready !== 1'b1) $display("FAIL flush_wr_ready got %b want 1", bus.wr_ready); else passed++;
      for (int i = 0; i < K; i++) push(i, beat_of(i*16));
      push(4, beat_of('h50));
      wait_cols(16);
      for (int c = 0; c < 16; c++) begin
         total++; if (done_q[c] !== (c == 7 || c == 15)) $display("FAIL flush_done%0d got %b want %b", c, done_q[c], c == 7 || c == 15); else passed++;
      end
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < K; i++) v[i] = (i < 4) ? (i+1)*16 + n : 'h50 + n;
         e = col5(v);
         total++; if (col_q[8+n] !== e) $display("FAIL flush_row1_col%0d got %h want %h", n, col_q[8+n], e); else passed++;
      end
      do_flush();
   endtask

   task automatic test_async_rst();
      cfg_recirc_en = 1'b0;
      cfg_line_len  = len_t'(8);
      bus.rd_ready  = 1'b1;
      for (int i = 0; i < K; i++) push(i, beat_of('h200 + i*16));
      @(posedge clk);
      #2;
      total++; if (bus.rd_valid !== 1'b1) $display("FAIL arst_pre_valid got %b want 1", bus.rd_valid); else passed++;
      rst = 1'b1;
      #1;
      total++; if (line_empty !== 5'h1f) $display("FAIL arst_empty got %h want 1f", line_empty); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL arst_rd_valid got %b want 0", bus.rd_valid); else passed++;
      total++; if (bus.row_done !== 1'b0) $display("FAIL arst_row_done got %b want 0", bus.row_done); else passed++;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (line_empty !== 5'h1f) $display("FAIL arst_after_empty got %h want 1f", line_empty); else passed++;
      total++; if (bus.rd_valid !== 1'b0) $display("FAIL arst_after_valid got %b want 0", bus.rd_valid); else passed++;
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_line  = '0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      test_reset();
      test_smoke();
      test_backpressure();
      test_recirc();
      test_partial_pad();
      test_priority();
      test_flush();
      test_async_rst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
